// File: rtl/fvmon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fvmon_pkg: shared types and helpers for the d/q follow monitor       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fvmon_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    WARMUP   = 2'd1,
    ACTIVE   = 2'd2
  } mon_state_e;

  localparam int FVMON_LAT_DEF   = 1;
  localparam int FVMON_CNT_W_DEF = 16;

  // Callers zero-extend into 64 bits and truncate the result back to their width.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max_val);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dq_hist_shift.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dq_hist_shift: LAT-deep {d, valid} history, oldest entry at output   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dq_hist_shift #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush_i,
  input  logic d_i,
  input  logic vld_i,
  output logic old_d_o,
  output logic old_vld_o
);

  logic [LAT-1:0] d_q;
  logic [LAT-1:0] d_d;
  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] vld_d;

  always_comb begin
    d_d      = d_q;
    vld_d    = vld_q;
    d_d[0]   = d_i;
    vld_d[0] = vld_i;
    for (int i = 1; i < LAT; i++) begin
      d_d[i]   = d_q[i-1];
      vld_d[i] = vld_q[i-1];
    end
    // A flush aborts every in-flight check rather than deferring it.
    if (flush_i) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q   <= '0;
      vld_q <= '0;
    end else begin
      d_q   <= d_d;
      vld_q <= vld_d;
    end
  end

  assign old_d_o   = d_q[LAT-1];
  assign old_vld_o = vld_q[LAT-1];

endmodule
`default_nettype wire

// File: rtl/dq_follow_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dq_follow_monitor: checks q equals d from LAT cycles earlier         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dq_follow_monitor
  import fvmon_pkg::*;
#(
  parameter int LAT   = FVMON_LAT_DEF,
  parameter int CNT_W = FVMON_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             disable_i,
  input  logic             check_all,
  input  logic             clear,
  input  logic             d,
  input  logic             q,
  output logic             fail_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_cyc,
  output logic [1:0]       state_o
);

  localparam int              WC_W    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [WC_W-1:0] WC_LOAD = WC_W'(LAT - 1);
  localparam logic [63:0]     CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(64'(v), CNT_MAX));
  endfunction

  mon_state_e       state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic             fail_pulse_q, fail_pulse_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [CNT_W-1:0] ffc_q, ffc_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  logic hist_d;
  logic hist_vld;
  logic chk_fire;
  logic chk_fail;

  dq_hist_shift #(
    .LAT (LAT)
  ) u_hist (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush_i   (disable_i),
    .d_i       (d),
    .vld_i     (~disable_i),
    .old_d_o   (hist_d),
    .old_vld_o (hist_vld)
  );

  // The DISABLED edge counts as the first of LAT warm-up edges.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (disable_i) begin
      state_d = DISABLED;
    end else begin
      case (state_q)
        DISABLED: begin
          wcnt_d  = WC_LOAD;
          state_d = (LAT == 1) ? ACTIVE : WARMUP;
        end
        WARMUP: begin
          wcnt_d = wcnt_q - WC_W'(1);
          if (wcnt_q <= WC_W'(1)) begin
            state_d = ACTIVE;
          end
        end
        ACTIVE:  state_d = ACTIVE;
        default: state_d = DISABLED;
      endcase
    end
  end

  always_comb begin
    chk_fire     = (state_q == ACTIVE) && hist_vld && !disable_i && (check_all || hist_d);
    chk_fail     = chk_fire && (q != hist_d);
    fail_pulse_d = chk_fail;
    pass_d       = pass_q;
    fail_d       = fail_q;
    err_d        = err_q;
    ffc_d        = ffc_q;
    cyc_d        = sat_cnt(cyc_q);
    // Clear wins over a same-edge result, but the pulse still reports it.
    if (clear) begin
      pass_d = '0;
      fail_d = '0;
      err_d  = 1'b0;
      ffc_d  = '0;
    end else begin
      if (chk_fire && !chk_fail) begin
        pass_d = sat_cnt(pass_q);
      end
      if (chk_fail) begin
        fail_d = sat_cnt(fail_q);
        if (!err_q) begin
          err_d = 1'b1;
          ffc_d = cyc_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= DISABLED;
      wcnt_q       <= '0;
      fail_pulse_q <= 1'b0;
      err_q        <= 1'b0;
      pass_q       <= '0;
      fail_q       <= '0;
      ffc_q        <= '0;
      cyc_q        <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      fail_pulse_q <= fail_pulse_d;
      err_q        <= err_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      ffc_q        <= ffc_d;
      cyc_q        <= cyc_d;
    end
  end

  assign fail_pulse     = fail_pulse_q;
  assign err_sticky     = err_q;
  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign first_fail_cyc = ffc_q;
  assign state_o        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_dq_follow_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dq_follow_monitor: two monitors (LAT=1/W=16, LAT=3/W=4) vs model  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dq_follow_monitor;

  logic        clk = 1'b0;
  logic        reset_n, disable_i, check_all, clear, d, q1, q3;
  logic        fp1, err1, fp3, err3;
  logic [15:0] pass1, fail1, ffc1;
  logic [3:0]  pass3, fail3, ffc3;
  logic [1:0]  st1, st3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dq_follow_monitor #(.LAT(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .disable_i(disable_i), .check_all(check_all),
    .clear(clear), .d(d), .q(q1), .fail_pulse(fp1), .err_sticky(err1),
    .pass_cnt(pass1), .fail_cnt(fail1), .first_fail_cyc(ffc1), .state_o(st1)
  );

  dq_follow_monitor #(.LAT(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .disable_i(disable_i), .check_all(check_all),
    .clear(clear), .d(d), .q(q3), .fail_pulse(fp3), .err_sticky(err3),
    .pass_cnt(pass3), .fail_cnt(fail3), .first_fail_cyc(ffc3), .state_o(st3)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a check at edge t needs disable_i low on every edge
  // from t-LAT through t since reset, i.e. a low-run of at least LAT+1.
  int m_run[2], m_pass[2], m_fail[2], m_cyc[2], m_ffc[2], m_state[2];
  bit m_err[2], m_pulse[2];
  bit m_hist[2][4];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int sat(input int v, input int k);
    int mx;
    mx = (k == 0) ? 65535 : 15;
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_pass[k] = 0; m_fail[k] = 0; m_cyc[k] = 0; m_ffc[k] = 0;
      m_state[k] = 0; m_err[k] = 1'b0; m_pulse[k] = 1'b0;
      for (int i = 0; i < 4; i++) m_hist[k][i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit qk, oldd, fire, failed;
    for (int k = 0; k < 2; k++) begin
      qk = (k == 0) ? q1 : q3;
      for (int i = 3; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
      m_hist[k][0] = d;
      m_run[k] = disable_i ? 0 : ((m_run[k] < 100) ? m_run[k] + 1 : 100);
      oldd   = m_hist[k][lat_of(k)];
      fire   = (m_run[k] >= lat_of(k) + 1) && (check_all || oldd);
      failed = fire && (qk != oldd);
      m_pulse[k] = failed;
      if (clear) begin
        m_pass[k] = 0; m_fail[k] = 0; m_err[k] = 1'b0; m_ffc[k] = 0;
      end else begin
        if (fire && !failed) m_pass[k] = sat(m_pass[k], k);
        if (failed) begin
          m_fail[k] = sat(m_fail[k], k);
          if (!m_err[k]) begin
            m_err[k] = 1'b1;
            m_ffc[k] = m_cyc[k];
          end
        end
      end
      m_cyc[k]   = sat(m_cyc[k], k);
      m_state[k] = disable_i ? 0 : ((m_run[k] >= lat_of(k)) ? 2 : 1);
    end
  endtask

  always @(negedge reset_n) model_reset();

  always @(posedge clk) begin
    if (reset_n) model_step();
    #1;
    chk("fp1",   int'(fp1),   int'(m_pulse[0]));
    chk("err1",  int'(err1),  int'(m_err[0]));
    chk("pass1", int'(pass1), m_pass[0]);
    chk("fail1", int'(fail1), m_fail[0]);
    chk("ffc1",  int'(ffc1),  m_ffc[0]);
    chk("st1",   int'(st1),   m_state[0]);
    chk("fp3",   int'(fp3),   int'(m_pulse[1]));
    chk("err3",  int'(err3),  int'(m_err[1]));
    chk("pass3", int'(pass3), m_pass[1]);
    chk("fail3", int'(fail3), m_fail[1]);
    chk("ffc3",  int'(ffc3),  m_ffc[1]);
    chk("st3",   int'(st3),   m_state[1]);
  end

  bit dlog[$];

  function automatic bit past(input int n);
    if (dlog.size() >= n) return dlog[dlog.size() - n];
    return 1'b0;
  endfunction

  task automatic drive(input bit rst, input bit dd, input bit dis, input bit ca,
                       input bit clr, input bit qa, input bit qb);
    @(negedge clk);
    reset_n = rst; d = dd; disable_i = dis; check_all = ca; clear = clr;
    q1 = qa; q3 = qb;
    dlog.push_back(dd);
    @(posedge clk);
    #2;
  endtask

  // q1/q3 follow d by their latency, optionally inverted to force failures.
  task automatic step(input bit dd, input bit dis, input bit ca, input bit clr,
                      input bit f1, input bit f3);
    drive(1'b1, dd, dis, ca, clr, past(1) ^ f1, past(3) ^ f3);
  endtask

  initial begin
    bit rd, rdis, rca, rclr, rf1, rf3;
    reset_n = 1'b0; disable_i = 1'b0; check_all = 1'b0; clear = 1'b0;
    d = 1'b0; q1 = 1'b0; q3 = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_st1", int'(st1), 0);
    chk("rst_fp1", int'(fp1), 0);
    chk("rst_pass1", int'(pass1), 0);
    chk("rst_st3", int'(st3), 0);
    chk("rst_err3", int'(err3), 0);

    // Implication mode, LAT=1: only d==1 samples are checked.
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("a_pass1", int'(pass1), 2);
    chk("a_mpass1", m_pass[0], 2);
    chk("a_fail1", int'(fail1), 0);
    step(0, 0, 0, 0, 1, 0);
    chk("b_fp1", int'(fp1), 1);
    chk("b_err1", int'(err1), 1);
    chk("b_fail1", int'(fail1), 1);
    chk("b_ffc1", int'(ffc1), 5);
    chk("b_mffc1", m_ffc[0], 5);
    step(0, 0, 0, 0, 0, 0);
    chk("b_fp1_off", int'(fp1), 0);

    // Disable on the edge that would have caught a mismatch.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    chk("c_fp1", int'(fp1), 0);
    chk("c_fail1", int'(fail1), 1);
    chk("c_st1", int'(st1), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("c_st1_act", int'(st1), 2);
    chk("c_st3_wu", int'(st3), 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("c_st3_act", int'(st3), 2);

    // LAT=3, check-all: first check lands exactly 3 edges after disable drops.
    step(0, 1, 1, 1, 0, 0);
    step($urandom_range(0, 1), 0, 1, 0, 0, 0);
    step($urandom_range(0, 1), 0, 1, 0, 0, 0);
    step($urandom_range(0, 1), 0, 1, 0, 0, 0);
    chk("d_pass3_pre", int'(pass3), 0);
    step($urandom_range(0, 1), 0, 1, 0, 0, 0);
    chk("d_pass3_first", int'(pass3), 1);
    repeat (16) step($urandom_range(0, 1), 0, 1, 0, 0, 0);
    chk("d_fail3", int'(fail3), 0);
    chk("d_fail1", int'(fail1), 0);

    // Saturation at 15 for CNT_W=4, then clear colliding with a failure.
    repeat (20) step($urandom_range(0, 1), 0, 1, 0, 0, 1);
    chk("e_fail3_sat", int'(fail3), 15);
    chk("e_mfail3_sat", m_fail[1], 15);
    chk("e_err3", int'(err3), 1);
    step($urandom_range(0, 1), 0, 1, 1, 0, 1);
    chk("e_fp3_clr", int'(fp3), 1);
    chk("e_fail3_clr", int'(fail3), 0);
    chk("e_pass3_clr", int'(pass3), 0);
    chk("e_err3_clr", int'(err3), 0);

    // Reset with mismatching checks in flight.
    step(1, 0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("f_fp3", int'(fp3), 0);
    chk("f_fail3", int'(fail3), 0);
    chk("f_err3", int'(err3), 0);
    chk("f_st3", int'(st3), 0);
    chk("f_pass1", int'(pass1), 0);
    drive(1'b0, 1, 0, 1, 0, 0, 0);
    drive(1'b0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 0, 0, 1, 0, 0, 0);
      chk("f_fp3_post", int'(fp3), 0);
    end
    chk("f_fail3_post", int'(fail3), 0);

    // Randomized traffic with occasional disable, clear, flips and resets.
    for (int i = 0; i < 1500; i++) begin
      rd   = 1'($urandom_range(0, 1));
      rdis = ($urandom_range(0, 9) == 0);
      rca  = 1'($urandom_range(0, 1));
      rclr = ($urandom_range(0, 39) == 0);
      rf1  = ($urandom_range(0, 7) == 0);
      rf3  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0)
        drive(1'b0, rd, rdis, rca, rclr, rf1, rf3);
      else
        step(rd, rdis, rca, rclr, rf1, rf3);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dq_follow_monitor.md
# dq_follow_monitor

Synthesizable, cycle-accurate observer for a registered data path: it checks that `q` equals the value `d` held `LAT` cycles earlier and reports pass/fail status in hardware. It replaces the simulation-only `disable iff` / `|=>` follow-check with RTL usable in emulation and formal harnesses. It sits beside the DUT and snoops the DUT's `d`/`q` pins, driving nothing back into the DUT.

## Interface
- `LAT`, default 1: check latency in cycles (≥1); `q` at cycle t+LAT is compared to `d` at cycle t.
- `CNT_W`, default 16: width of the pass, fail and cycle counters.
- `clk`  in  1  sole clock; all sampling on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `disable_i`  in  1  synchronous check disable; equivalent to `disable iff`.
- `check_all`  in  1  1: check every cycle; 0: check only cycles where sampled `d`==1 (implication mode).
- `clear`  in  1  synchronous clear of counters, sticky error and capture register.
- `d`  in  1  DUT data input, snooped.
- `q`  in  1  DUT data output, snooped.
- `fail_pulse`  out  1  one-cycle pulse per failed check.
- `err_sticky`  out  1  set on first failure, held until `clear` or reset.
- `pass_cnt`  out  CNT_W  saturating count of passed checks.
- `fail_cnt`  out  CNT_W  saturating count of failed checks.
- `first_fail_cyc`  out  CNT_W  `cycle_cnt` value at the first failure since the last clear.
- `state_o`  out  2  current FSM state encoding.

## Operation
- FSM states: DISABLED, WARMUP, ACTIVE.
  - Reset enters DISABLED.
  - DISABLED → WARMUP when `disable_i`==0.
  - WARMUP loads a counter with LAT-1. It moves to ACTIVE when the counter reaches 0, so DISABLED → ACTIVE takes exactly LAT edges with `disable_i` low.
  - Any state → DISABLED on any edge that samples `disable_i`==1.
- History: a LAT-deep shift register holds {d, valid}. Per edge it shifts in {d, ~disable_i}.
  - All valid bits clear on reset and on any edge sampling `disable_i`==1. In-flight checks are aborted, not deferred.
- A check fires at an edge when all of the following hold:
  - the state is ACTIVE;
  - the oldest history entry is valid;
  - `disable_i`==0;
  - `check_all`==1 or the oldest d==1.
- A check fails when the sampled `q` differs from the oldest history d. Otherwise it passes.
- Counter updates:
  - `pass_cnt` and `fail_cnt` increment by 1 per check and saturate at 2^CNT_W-1.
  - `cycle_cnt` (internal) increments every edge after reset and saturates at 2^CNT_W-1.
- On the first failure (`err_sticky`==0), `first_fail_cyc` captures `cycle_cnt` as it was before that edge. Later failures do not overwrite it.
- `clear` has priority over a same-edge check. The counters, `err_sticky` and `first_fail_cyc` go to 0, and that edge's result is dropped. `fail_pulse` still reflects that edge's failure.
- `disable_i` has priority over `check_all`, `clear` does not depend on state, and `clear` does not reset `cycle_cnt`.

## Timing
- Reset values:
  - all outputs are 0;
  - `state_o` is DISABLED;
  - the history is all invalid.
- Latency: a check on `d` sampled at edge t is evaluated at edge t+LAT. `fail_pulse`, the counters and `err_sticky` are registered and become visible right after edge t+LAT.
- `fail_pulse` is high for exactly one cycle per failure. Back-to-back failures hold it high on consecutive cycles.
- Asserting `reset_n` mid-check discards all pending checks immediately, with no residual pulse.
- When `disable_i` drops, the first possible check is LAT edges later. Data sampled while `disable_i` was high is never checked.

## Structure
- Shared package `fvmon_pkg` contains:
  - the `mon_state_e` enum (DISABLED=0, WARMUP=1, ACTIVE=2);
  - default constants `FVMON_LAT_DEF`=1 and `FVMON_CNT_W_DEF`=16;
  - a saturating-increment function.
- Sub-module `dq_hist_shift` (parameter `LAT`) is the history shift register with an async-clear and sync-flush valid bit. It outputs the oldest {d, valid}.
- The top level holds the FSM, the check logic, the counters and the capture register.

## Test plan
- LAT=1, check_all=0: release reset, `disable_i`=0, then d=0,1,0,1 with q following one cycle later. Required: `pass_cnt`=2, `fail_cnt`=0, `fail_pulse` never high.
- LAT=1: d=1 at edge 5, q=0 at edge 6. Required: `fail_pulse` high for one cycle after edge 6; `err_sticky`=1; `fail_cnt`=1; `first_fail_cyc`=5.
- `disable_i` high on the edge between d=1 and the expected q=0 mismatch. Required: no fail. After `disable_i` drops, `state_o` shows WARMUP/ACTIVE after LAT edges.
- LAT=3, check_all=1: q is d delayed by 3 cycles. Required: `fail_cnt`=0, and the first check occurs exactly 3 edges after `disable_i`=0.
- CNT_W=4, continuous failures for 20 checks. Required: `fail_cnt` saturates at 15. Then `clear` coincident with a failure: counters=0, `err_sticky`=0, `fail_pulse`=1.
- `reset_n` pulsed low while 2 checks are in flight (LAT=3). Required: all outputs are 0 immediately, and no `fail_pulse` occurs afterwards for the pre-reset data.
